// File: rtl/value_weight_stream_fetch.sv
// value_weight_stream_fetch
// Streams weight words out of a parameter ROM that has a fixed 2-cycle
// registered read and no handshake. Reads are issued only against buffer
// credit (FIFO occupancy plus reads still in the ROM pipeline). This means
// every returned word has a guaranteed FIFO slot. Words leave in address
// order 0..OUT_DEPTH-1, wrapping forever. The final word of each pass is
// flagged with data_out_last.

module value_weight_stream_fetch #(
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PRECISION_0       = 16,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int OUT_DEPTH         = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    parameter int FIFO_DEPTH        = 4,
    parameter int ADDR_WIDTH        = $clog2(OUT_DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic [ADDR_WIDTH-1:0]                  rom_addr,
    output logic                                   rom_ce,
    input  logic [PRECISION_0*TENSOR_SIZE_DIM_0-1:0] rom_q,
    output logic [PRECISION_0-1:0]                 data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                                   data_out_valid,
    output logic                                   data_out_last,
    input  logic                                   data_out_ready
);

    localparam int P      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int LANE_W = PRECISION_0 * P;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;

    // Only the lane bits of a ROM word are ever presented, so only those are buffered.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Address generator and read tracker (bit 0 = stage 1, bit 1 = stage 2)
    logic [ADDR_WIDTH-1:0] rom_addr_r;
    logic [1:0]            trk_v_r;
    logic [1:0]            trk_last_r;

    // Output FIFO storage, pointers and occupancy
    logic [LANE_W-1:0]     fifo_word_r [FIFO_DEPTH];
    logic                  fifo_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    // Registered head of the FIFO, driven straight onto the output port
    logic [LANE_W-1:0]     head_word_r;
    logic                  head_last_r;
    logic                  head_valid_r;

    // Next-state terms
    logic [SUM_W-1:0]      credit_sum_s;
    logic                  issue_s;
    logic                  addr_is_last_s;
    logic [ADDR_WIDTH-1:0] addr_next_s;
    logic                  push_s;
    logic                  pop_s;
    logic [PTR_W-1:0]      rd_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic                  valid_next_s;
    logic [LANE_W-1:0]     head_word_next_s;
    logic                  head_last_next_s;

    // Whole-word fold so the unbuffered upper ROM bits are consumed explicitly.
    logic                  unused_rom_parity_s;
    assign unused_rom_parity_s = ^rom_q;

    // The ROM pipeline advances whenever the block is out of reset, fixing latency at 2.
    assign rom_ce   = !rst;
    assign rom_addr = rom_addr_r;

    // Credit check and address sequencing; a same-cycle pop deliberately gives no credit.
    always_comb begin
        credit_sum_s   = SUM_W'(count_r) + SUM_W'(trk_v_r[0]) + SUM_W'(trk_v_r[1]);
        issue_s        = (credit_sum_s < SUM_W'(FIFO_DEPTH));
        addr_is_last_s = (rom_addr_r == ADDR_WIDTH'(OUT_DEPTH - 1));
        if (addr_is_last_s) begin
            addr_next_s = ADDR_WIDTH'(0);
        end else begin
            addr_next_s = rom_addr_r + ADDR_WIDTH'(1);
        end
    end

    // FIFO bookkeeping and look-ahead of the next head entry for the output register.
    always_comb begin
        push_s = trk_v_r[1];
        pop_s  = head_valid_r && data_out_ready;
        if (pop_s) begin
            rd_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
        valid_next_s = (count_next_s != CNT_W'(0));
        // A word written into the slot that becomes the head must bypass the array.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_word_next_s = rom_q[LANE_W-1:0];
            head_last_next_s = trk_last_r[1];
        end else begin
            head_word_next_s = fifo_word_r[rd_next_s];
            head_last_next_s = fifo_last_r[rd_next_s];
        end
        if (!valid_next_s) begin
            head_last_next_s = 1'b0;
        end else begin
            head_last_next_s = head_last_next_s;
        end
    end

    // Address counter and 2-stage in-flight tracker; reset discards any ROM data in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_r <= ADDR_WIDTH'(0);
            trk_v_r    <= 2'b00;
            trk_last_r <= 2'b00;
        end else begin
            if (issue_s) begin
                rom_addr_r <= addr_next_s;
            end
            trk_v_r    <= {trk_v_r[0], issue_s};
            trk_last_r <= {trk_last_r[0], issue_s & addr_is_last_s};
        end
    end

    // FIFO array, pointers, occupancy and registered head/valid/last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word_r[i] <= LANE_W'(0);
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            head_word_r  <= LANE_W'(0);
            head_last_r  <= 1'b0;
            head_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_word_r[wr_ptr_r] <= rom_q[LANE_W-1:0];
                fifo_last_r[wr_ptr_r] <= trk_last_r[1];
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            rd_ptr_r     <= rd_next_s;
            count_r      <= count_next_s;
            head_word_r  <= head_word_next_s;
            head_last_r  <= head_last_next_s;
            head_valid_r <= valid_next_s;
        end
    end

    // Split the registered head word into output lanes.
    always_comb begin
        for (int j = 0; j < P; j++) begin
            data_out[j] = head_word_r[PRECISION_0*j +: PRECISION_0];
        end
    end

    assign data_out_valid = head_valid_r;
    assign data_out_last  = head_last_r;

    value_weight_stream_fetch_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// value_weight_stream_fetch_chk
// Invariants of the credit scheme: the FIFO is never written while full.
module value_weight_stream_fetch_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (count <= CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_value_weight_stream_fetch.sv
// Bench for value_weight_stream_fetch: a ROM model with 2-cycle latency, a
// scoreboard of expected beats (word index mod 32 after each reset), and a
// monitor that checks every accepted beat. Directed checks cover timing.

module tb_value_weight_stream_fetch;

    localparam int ROM_W  = 512;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 32;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce;
    logic [ROM_W-1:0]  rom_q  = '0;
    logic [ROM_W-1:0]  rom_s1 = '0;
    logic [15:0]       data_out [1];
    logic              data_out_valid;
    logic              data_out_last;
    logic              data_out_ready = 1'b0;

    int    checks     = 0;
    int    passes     = 0;
    int    accepted   = 0;
    int    last_seen  = 0;
    beat_t sb [$];

    value_weight_stream_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_q          (rom_q),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_last  (data_out_last),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    // ROM contents: word k, lane j = k*16 + j.
    function automatic logic [ROM_W-1:0] rom_word(input int k);
        logic [ROM_W-1:0] w;
        for (int j = 0; j < 32; j++) begin
            w[16*j +: 16] = 16'(k * 16 + j);
        end
        return w;
    endfunction

    // Two-stage registered ROM read, advancing only with rom_ce.
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_s1 <= rom_word(int'(rom_addr));
            rom_q  <= rom_s1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream after reset release: word i mod 32, last on word 31.
    task automatic push_expected(input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = 16'((k % DEPTH) * 16);
            b.last = ((k % DEPTH) == DEPTH - 1);
            sb.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds rst for n cycles, then leaves the caller 1 ns into cycle 0.
    task automatic do_reset(input int n);
        step();
        rst = 1'b1;
        sb.delete();
        repeat (n) step();
        rst = 1'b0;
        push_expected(600);
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", 32'(data_out[0]), 32'(e.data));
                check("beat_last", 32'(data_out_last), 32'(e.last));
            end
            if (data_out_last) begin
                last_seen++;
            end
            accepted++;
        end
    end

    initial begin
        int acc0;
        int last0;
        int bubbles;
        int bad;
        bit hit;

        // Reset values
        @(negedge clk);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_last", 32'(data_out_last), 32'd0);
        check("rst_data", 32'(data_out[0]), 32'd0);
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);

        // Cold start and three full passes with ready high
        data_out_ready = 1'b1;
        do_reset(2);
        acc0    = accepted;
        last0   = last_seen;
        bubbles = 0;
        for (int c = 0; c < 99; c++) begin
            @(negedge clk);
            if (c == 0) check("run_rom_ce", 32'(rom_ce), 32'd1);
            if (c < 3) check("cold_pre_valid", 32'(data_out_valid), 32'd0);
            if (c == 3) begin
                check("cold_first_valid", 32'(data_out_valid), 32'd1);
                check("cold_first_data", 32'(data_out[0]), 32'h0000);
            end
            if (c >= 3 && !data_out_valid) bubbles++;
            step();
        end
        data_out_ready = 1'b0;
        @(negedge clk);
        check("wrap_bubbles", 32'(bubbles), 32'd0);
        check("wrap_last_count", 32'(last_seen - last0), 32'd3);
        check("wrap_beats", 32'(accepted - acc0), 32'd96);

        // Backpressure from cycle 3 for 20 cycles
        data_out_ready = 1'b1;
        do_reset(1);
        repeat (3) step();
        data_out_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!data_out_valid || data_out[0] !== 16'h0000 || data_out_last) bad++;
            step();
        end
        @(negedge clk);
        check("stall_hold", 32'(bad), 32'd0);
        check("stall_rom_addr", 32'(rom_addr), 32'd4);
        step();
        data_out_ready = 1'b1;
        acc0 = accepted;
        repeat (40) step();
        data_out_ready = 1'b0;
        @(negedge clk);
        check("stall_release_beats", 32'(accepted - acc0), 32'd40);

        // Random ready, continuing the same stream
        acc0 = accepted;
        for (int c = 0; c < 200; c++) begin
            step();
            data_out_ready = 1'($urandom_range(0, 1));
        end
        step();
        data_out_ready = 1'b0;
        @(negedge clk);
        check("rand_some_accepted", 32'(accepted - acc0 > 40), 32'd1);

        // Mid-stream reset after 10 accepted beats
        step();
        data_out_ready = 1'b1;
        acc0 = accepted;
        hit  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (accepted - acc0 >= 10) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("mid_reached_10", 32'(hit), 32'd1);
        do_reset(1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) check("mid_valid_low", 32'(data_out_valid), 32'd0);
            if (c == 3) begin
                check("mid_first_valid", 32'(data_out_valid), 32'd1);
                check("mid_first_data", 32'(data_out[0]), 32'h0000);
            end
            step();
        end

        // Stall with word 31 at the head
        data_out_ready = 1'b1;
        do_reset(1);
        repeat (34) step();
        data_out_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!data_out_valid || !data_out_last || data_out[0] !== 16'h01F0) bad++;
            step();
        end
        check("last_stall_hold", 32'(bad), 32'd0);
        data_out_ready = 1'b1;
        step();
        @(negedge clk);
        check("after_last_data", 32'(data_out[0]), 32'h0000);
        check("after_last_flag", 32'(data_out_last), 32'd0);
        check("after_last_valid", 32'(data_out_valid), 32'd1);
        step();
        data_out_ready = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
